display_frame_buffer: RTL
=========================

DISPLAY_FRAME_BUFFER -- requirements
Module: display_frame_buffer

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-003 seg_sel  input  3  current digit index from the anode scan controller; advances 0..7 then wraps to 0.
REQ-004 wr_valid  input  1  write request; qualifies wr_data, wr_dp and wr_blank_lz.
REQ-005 wr_ready  output  1  buffer can accept a write this cycle.
REQ-006 wr_data  input  32  eight hex nibbles; nibble k = bits [4k+3:4k] = digit k.
REQ-007 wr_dp  input  8  decimal-point mask; bit k = 1 lights the dp on digit k.
REQ-008 wr_blank_lz  input  1  1 = enable leading-zero blanking.
REQ-009 seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-010 dp  output  1  decimal-point cathode, active-low.
REQ-011 pending  output  1  shadow holds data not yet displayed.
REQ-012 frame_done  output  1  one-cycle pulse, registered, one cycle after each detected frame boundary.

Function
REQ-013 Write handshake: transfer occurs when wr_valid=1 and wr_ready=1 in the same cycle.
REQ-014 wr_ready = NOT pending (combinational).
REQ-015 On transfer, shadow registers (data, dp mask, blank_lz) capture inputs and pending is set to 1 on the same edge.
REQ-016 Frame boundary = registered previous seg_sel equals 7 and current seg_sel equals 0, evaluated each cycle.
REQ-017 At a frame boundary with pending=1: active registers load the shadow and pending clears on the same edge.
REQ-018 At a frame boundary with pending=0: active registers hold their value.
REQ-019 Transfer and boundary in the same cycle: pending was 0, so there is no active update; the new data goes to shadow and is displayed from the next boundary onward.
REQ-020 Active registers never change except at a frame boundary, so no partial frame is ever shown.
REQ-021 seg and dp are combinational from seg_sel and the active registers, with zero latency, so they align with the combinational anode outputs.
REQ-022 Hex decode (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-023 Leading-zero blanking: with active blank_lz=1, digit k (k=1..7) is blanked if active nibbles k..7 are all zero; digit 0 is never blanked.
REQ-024 A blanked digit drives seg=1111111; dp still follows the active dp mask.
REQ-025 dp = NOT active_dp[seg_sel].
REQ-026 frame_done pulses on every boundary, regardless of pending.
REQ-027 A seg_sel jump other than 7->0 is not a boundary; outputs still follow seg_sel.

Reset
REQ-028 While reset=0: shadow and active data = 0, dp masks = 0, blank_lz (shadow and active) = 1, pending=0, prev seg_sel=0, frame_done=0.
REQ-029 Resulting outputs with seg_sel=0: seg=1000000, dp=1, wr_ready=1; digits 1..7 blank.
REQ-030 Reset asserted mid-operation discards the shadow and any pending data immediately; no partial update occurs.

Structure
REQ-031 A shared package holds the 16 segment-pattern constants, SEG_BLANK=7'h7F, and the digit-count constant 8.
REQ-032 One sub-module, hex_to_7seg (4-bit in, 7-bit active-low out, purely combinational), is instantiated once on the selected nibble.

Verification
REQ-033 Release reset, seg_sel cycles 0..7 -> seg=1000000 on digit 0, 1111111 on digits 1..7, dp=1 on all digits, frame_done pulses once per wrap.
REQ-034 Write 32'h0000_00A5 with blank_lz=1 and dp=8'h01 mid-frame -> pending=1 and wr_ready=0 until the next 7->0; from the following frame digit0=0010010 (dp=0), digit1=0001000, digits 2..7 blank.
REQ-035 Write 32'h1234_5678 with blank_lz=0, then hold wr_valid=1 with 32'hFFFF_FFFF before the boundary -> the second write stalls (wr_ready=0); the display shows 12345678 after boundary 1 and FFFFFFFF after boundary 2.
REQ-036 Assert wr_valid in the same cycle as the 7->0 boundary -> active is unchanged that frame; the new value appears after the next boundary.
REQ-037 Assert reset while pending=1 -> pending=0, seg=1000000 at seg_sel=0, and the old data is never displayed.
REQ-038 Write 32'h0000_0000 with blank_lz=1 -> only digit 0 shows 1000000; write 32'h8000_0000 -> all eight digits are lit, including the zero digits.

Source files
------------

// File: rtl/display_frame_buffer_pkg.sv
// display_frame_buffer_pkg: digit count, segment patterns and the frame
// record shared by the eight-digit frame buffer and its hex decoder.
package display_frame_buffer_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEL_W      = 3;
  localparam int DATA_W     = 4 * NUM_DIGITS;

  // Cathode patterns ordered {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;

  // One complete frame: eight nibbles, the dp mask and the blanking enable.
  typedef struct packed {
    logic [DATA_W-1:0]     data;
    logic [NUM_DIGITS-1:0] dp;
    logic                  blank_lz;
  } frame_t;

  // After reset the display shows a single 0 with blanking enabled.
  localparam frame_t FRAME_RESET = '{data: '0, dp: '0, blank_lz: 1'b1};

endpackage

// File: rtl/display_frame_buffer_hex_to_7seg.sv
// hex_to_7seg: purely combinational nibble to active-low seven-segment decoder.
module hex_to_7seg
  import display_frame_buffer_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Look up the cathode pattern for the incoming hex digit.
  always_comb begin
    seg_o = SEG_BLANK;
    case (hex_i)
      4'h0: seg_o = SEG_HEX_0;
      4'h1: seg_o = SEG_HEX_1;
      4'h2: seg_o = SEG_HEX_2;
      4'h3: seg_o = SEG_HEX_3;
      4'h4: seg_o = SEG_HEX_4;
      4'h5: seg_o = SEG_HEX_5;
      4'h6: seg_o = SEG_HEX_6;
      4'h7: seg_o = SEG_HEX_7;
      4'h8: seg_o = SEG_HEX_8;
      4'h9: seg_o = SEG_HEX_9;
      4'hA: seg_o = SEG_HEX_A;
      4'hB: seg_o = SEG_HEX_B;
      4'hC: seg_o = SEG_HEX_C;
      4'hD: seg_o = SEG_HEX_D;
      4'hE: seg_o = SEG_HEX_E;
      4'hF: seg_o = SEG_HEX_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_frame_buffer.sv
// display_frame_buffer: double-buffered eight-digit display store. Writes land
// in a shadow frame and are promoted to the active frame only on a 7->0 scan
// wrap, so the multiplexed display never shows a mix of two frames.
module display_frame_buffer
  import display_frame_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SEL_W-1:0]      seg_sel,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [NUM_DIGITS-1:0] wr_dp,
  input  logic                  wr_blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  pending,
  output logic                  frame_done
);

  frame_t                shadow_q, shadow_d;
  frame_t                active_q, active_d;
  logic                  pending_q, pending_d;
  logic [SEL_W-1:0]      prevSel_q;
  logic                  frameDone_q;
  logic                  frameBoundary;
  logic                  writeFire;
  logic                  upperZero;
  logic [NUM_DIGITS-1:0] lzMask;
  logic [3:0]            curNibble;
  logic [6:0]            decodedSeg;

  assign frameBoundary = (prevSel_q == SEL_W'(NUM_DIGITS - 1)) && (seg_sel == '0);
  assign writeFire     = wr_valid && !pending_q;
  assign wr_ready      = !pending_q;
  assign pending       = pending_q;
  assign frame_done    = frameDone_q;

  // Promote a waiting shadow at the wrap, then accept a new write into the
  // shadow; a write is only taken while nothing is waiting, so the two never
  // collide and a write on the wrap cycle waits for the following wrap.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (frameBoundary && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (writeFire) begin
      shadow_d  = '{data: wr_data, dp: wr_dp, blank_lz: wr_blank_lz};
      pending_d = 1'b1;
    end
  end

  // State registers; reset drops any waiting frame immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q    <= FRAME_RESET;
      active_q    <= FRAME_RESET;
      pending_q   <= 1'b0;
      prevSel_q   <= '0;
      frameDone_q <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      prevSel_q   <= seg_sel;
      frameDone_q <= frameBoundary;
    end
  end

  // Mark digits whose own nibble and every more-significant nibble are zero;
  // digit 0 is never marked so a zero value still shows a single 0.
  always_comb begin
    lzMask    = '0;
    upperZero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upperZero = upperZero && (active_q.data[4*k +: 4] == 4'h0);
      lzMask[k] = upperZero && active_q.blank_lz;
    end
  end

  assign curNibble = active_q.data[{seg_sel, 2'b00} +: 4];

  hex_to_7seg u_hexToSeg (
    .hex_i (curNibble),
    .seg_o (decodedSeg)
  );

  assign seg = lzMask[seg_sel] ? SEG_BLANK : decodedSeg;
  assign dp  = ~active_q.dp[seg_sel];

endmodule
